// File: rtl/cp0_pkg.sv
// CP0 shared definitions: ExcCodes, register addresses, Status bits,
// and the exception sequencer state/selection types.
package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 10;
  localparam int ST_IM_HI = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAKE,
    S_ERET,
    S_DRAIN,
    S_REDIRECT
  } exc_state_e;

  typedef enum logic [1:0] {
    BADV_NONE,
    BADV_PC,
    BADV_ADDR
  } badv_sel_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// Commit-stage to exception sequencer bus; master is the pipeline side,
// slave is exc_ctrl.
interface exc_ctrl_if;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mem_addr_i;
  logic        exc_adel_if_i;
  logic        exc_ri_i;
  logic        exc_sys_i;
  logic        exc_bp_i;
  logic        exc_ov_i;
  logic        exc_adel_i;
  logic        exc_ades_i;
  logic        eret_i;
  logic [5:0]  int_i;
  logic [31:0] status_i;
  logic [31:0] epc_i;
  logic        mem_kill_o;
  logic        cp0_exc_we_o;
  logic [4:0]  cp0_exc_code_o;
  logic        cp0_epc_we_o;
  logic [31:0] cp0_epc_o;
  logic        cp0_badv_we_o;
  logic [31:0] cp0_badv_o;
  logic        cp0_eret_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_addr_i,
    input  exc_adel_if_i, exc_ri_i, exc_sys_i, exc_bp_i,
    input  exc_ov_i, exc_adel_i, exc_ades_i, eret_i,
    input  int_i, status_i, epc_i,
    output mem_kill_o, cp0_exc_we_o, cp0_exc_code_o,
    output cp0_epc_we_o, cp0_epc_o, cp0_badv_we_o, cp0_badv_o,
    output cp0_eret_o, flush_o, redirect_o, redirect_pc_o, busy_o
  );

  modport master (
    output mem_valid_i, mem_pc_i, mem_addr_i,
    output exc_adel_if_i, exc_ri_i, exc_sys_i, exc_bp_i,
    output exc_ov_i, exc_adel_i, exc_ades_i, eret_i,
    output int_i, status_i, epc_i,
    input  mem_kill_o, cp0_exc_we_o, cp0_exc_code_o,
    input  cp0_epc_we_o, cp0_epc_o, cp0_badv_we_o, cp0_badv_o,
    input  cp0_eret_o, flush_o, redirect_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority selection of one exception from the commit flags
// plus a qualified interrupt request.
module exc_prio_enc
  import cp0_pkg::*;
(
  input  logic       int_req_i,
  input  logic       adel_if_i,
  input  logic       ri_i,
  input  logic       sys_i,
  input  logic       bp_i,
  input  logic       ov_i,
  input  logic       adel_i,
  input  logic       ades_i,
  output logic       valid_o,
  output logic [4:0] code_o,
  output badv_sel_e  badv_sel_o
);

  always_comb begin
    valid_o    = 1'b1;
    code_o     = EXC_INT;
    badv_sel_o = BADV_NONE;
    priority case (1'b1)
      int_req_i: code_o = EXC_INT;
      adel_if_i: begin
        code_o     = EXC_ADEL;
        badv_sel_o = BADV_PC;
      end
      ri_i:  code_o = EXC_RI;
      sys_i: code_o = EXC_SYS;
      bp_i:  code_o = EXC_BP;
      ov_i:  code_o = EXC_OV;
      adel_i: begin
        code_o     = EXC_ADEL;
        badv_sel_o = BADV_ADDR;
      end
      ades_i: begin
        code_o     = EXC_ADES;
        badv_sel_o = BADV_ADDR;
      end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: CP0 strobes, flush drain, PC redirect.
// Interrupt path is built only when EXC_CTRL_INT_EN is defined.
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  exc_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] target_q, target_d;
  logic        exc_we_q, exc_we_d;
  logic        epc_we_q, epc_we_d;
  logic        badv_we_q, badv_we_d;
  logic        eret_q, eret_d;
  logic        flush_q, flush_d;
  logic        redir_q, redir_d;

  logic        int_req;
  logic        enc_valid;
  logic [4:0]  enc_code;
  badv_sel_e   enc_sel;
  logic        unused_bits;

`ifdef EXC_CTRL_INT_EN
  logic [5:0] int_q, int_d;

  assign int_d = bus.int_i;

  always_ff @(posedge clk) begin
    if (rst) int_q <= '0;
    else     int_q <= int_d;
  end

  assign int_req = bus.status_i[ST_IE]
                 & ~bus.status_i[ST_EXL]
                 & |(int_q & bus.status_i[ST_IM_HI:ST_IM_LO]);
  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[9:2]};
`else
  assign int_req     = 1'b0;
  assign unused_bits = ^{bus.int_i, bus.status_i[31:2],
                         bus.status_i[0]};
`endif

  exc_prio_enc u_enc (
    .int_req_i  (int_req),
    .adel_if_i  (bus.exc_adel_if_i),
    .ri_i       (bus.exc_ri_i),
    .sys_i      (bus.exc_sys_i),
    .bp_i       (bus.exc_bp_i),
    .ov_i       (bus.exc_ov_i),
    .adel_i     (bus.exc_adel_i),
    .ades_i     (bus.exc_ades_i),
    .valid_o    (enc_valid),
    .code_o     (enc_code),
    .badv_sel_o (enc_sel)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    epc_d     = epc_q;
    badv_d    = badv_q;
    target_d  = target_q;
    exc_we_d  = 1'b0;
    epc_we_d  = 1'b0;
    badv_we_d = 1'b0;
    eret_d    = 1'b0;
    flush_d   = 1'b0;
    redir_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_valid_i && enc_valid) begin
          state_d   = S_TAKE;
          code_d    = enc_code;
          epc_d     = bus.mem_pc_i;
          target_d  = EXC_VECTOR;
          exc_we_d  = 1'b1;
          epc_we_d  = ~bus.status_i[ST_EXL];
          badv_we_d = (enc_sel != BADV_NONE);
          flush_d   = 1'b1;
          if (enc_sel == BADV_PC)   badv_d = bus.mem_pc_i;
          if (enc_sel == BADV_ADDR) badv_d = bus.mem_addr_i;
        end else if (bus.mem_valid_i && bus.eret_i) begin
          state_d  = S_ERET;
          target_d = bus.epc_i;
          eret_d   = 1'b1;
          flush_d  = 1'b1;
        end
      end
      S_TAKE, S_ERET: begin
        state_d = S_DRAIN;
        cnt_d   = 4'(FLUSH_CYCLES - 1);
        flush_d = 1'b1;
      end
      S_DRAIN: begin
        flush_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_REDIRECT;
          redir_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      epc_q     <= '0;
      badv_q    <= '0;
      target_q  <= '0;
      exc_we_q  <= 1'b0;
      epc_we_q  <= 1'b0;
      badv_we_q <= 1'b0;
      eret_q    <= 1'b0;
      flush_q   <= 1'b0;
      redir_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
      target_q  <= target_d;
      exc_we_q  <= exc_we_d;
      epc_we_q  <= epc_we_d;
      badv_we_q <= badv_we_d;
      eret_q    <= eret_d;
      flush_q   <= flush_d;
      redir_q   <= redir_d;
    end
  end

  // ERET alone never kills: the instruction has no writeback to guard
  assign bus.mem_kill_o = bus.mem_valid_i
                        & ((state_q != S_IDLE) | enc_valid);

  assign bus.cp0_exc_we_o   = exc_we_q;
  assign bus.cp0_exc_code_o = code_q;
  assign bus.cp0_epc_we_o   = epc_we_q;
  assign bus.cp0_epc_o      = epc_q;
  assign bus.cp0_badv_we_o  = badv_we_q;
  assign bus.cp0_badv_o     = badv_q;
  assign bus.cp0_eret_o     = eret_q;
  assign bus.flush_o        = flush_q;
  assign bus.redirect_o     = redir_q;
  assign bus.redirect_pc_o  = target_q;
  assign bus.busy_o         = (state_q != S_IDLE);

endmodule
